// File: rtl/iter_alu_pkg.sv
// Shared definitions for the iterative ALU: opcode encodings and FSM state codes.
// Imported by the top level and the testbench.
package iter_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADDU = 4'd1,
    OP_SUB  = 4'd2,
    OP_SUBU = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_SLT  = 4'd7,
    OP_SLTU = 4'd8,
    OP_LUI  = 4'd9,
    OP_MULU = 4'd10,
    OP_DIVU = 4'd11
  } op_e;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MUL  = 2'd1;
  localparam state_t ST_DIV  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/iter_alu_if.sv
// Request/response bundle of the iterative ALU.
// The master drives the request; the slave (the ALU) returns the ready, the result and the flags.
interface iter_alu_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             div_zero;

  modport master (
    output in_valid, op, a, b,
    input  in_ready, out_valid, result, result_hi, carry_out, overflow, zero, div_zero
  );

  modport slave (
    input  in_valid, op, a, b,
    output in_ready, out_valid, result, result_hi, carry_out, overflow, zero, div_zero
  );
endinterface

// File: rtl/iter_muldiv.sv
// Iterative engine: unsigned shift-add multiply or restoring divide, one bit per cycle.
// lo/hi show the value after the iteration in progress, so they are final while done is high.
module iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_hi, r_lo, r_b;
  logic             r_is_div;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_sum, w_shift;
  logic [WIDTH-1:0] w_sub, w_hi_next, w_lo_next;
  logic             w_ge;

  // Multiply: {hi,lo} holds partial product / multiplier. Divide: hi = remainder, lo = dividend/quotient.
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_shift = {r_hi, r_lo[WIDTH-1]};
    w_ge    = w_shift >= {1'b0, r_b};
    w_sub   = w_shift[WIDTH-1:0] - r_b;
    if (r_is_div) begin
      w_hi_next = w_ge ? w_sub : w_shift[WIDTH-1:0];
      w_lo_next = {r_lo[WIDTH-2:0], w_ge};
    end else begin
      w_hi_next = w_sum[WIDTH:1];
      w_lo_next = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_cnt    <= '0;
    end else if (start) begin
      r_hi     <= '0;
      r_lo     <= a;
      r_b      <= b;
      r_is_div <= is_div;
      r_cnt    <= CW'(WIDTH);
    end else if (busy) begin
      r_hi     <= w_hi_next;
      r_lo     <= w_lo_next;
      r_cnt    <= r_cnt - CW'(1);
    end
  end

  // A zero divisor needs no special case: every trial subtract succeeds,
  // leaving an all-ones quotient and the dividend as remainder.
  assign busy = (r_cnt != '0);
  assign done = (r_cnt == CW'(1));
  assign lo   = w_lo_next;
  assign hi   = w_hi_next;

endmodule

// File: rtl/iter_alu.sv
// Iterative ALU top: single-cycle ops registered straight into the result fields,
// MULU/DIVU handed to iter_muldiv; results are held until the next out_valid.
module iter_alu
  import iter_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input logic        clk,
  input logic        reset,
  iter_alu_if.slave  bus
);
  state_t           r_state;
  logic [WIDTH-1:0] r_result, r_result_hi;
  logic             r_carry, r_ovf, r_zero, r_div_zero, r_b_zero;

  logic             w_accept, w_is_mul, w_is_div;
  logic             w_md_busy, w_md_done;
  logic [WIDTH-1:0] w_md_lo, w_md_hi;
  logic [WIDTH:0]   w_sum, w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_carry, w_ovf, w_zero, w_known;

  assign bus.in_ready = ~w_md_busy & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_is_mul     = (bus.op == OPW'(OP_MULU));
  assign w_is_div     = (bus.op == OPW'(OP_DIVU));

  iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (w_accept & (w_is_mul | w_is_div)),
    .is_div (w_is_div),
    .a      (bus.a),
    .b      (bus.b),
    .busy   (w_md_busy),
    .done   (w_md_done),
    .lo     (w_md_lo),
    .hi     (w_md_hi)
  );

  assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_diff = {1'b0, bus.a} - {1'b0, bus.b};

  // Evaluated on the accepted operands and latched on the accept edge, giving out_valid one cycle later.
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_known = 1'b1;
    case (bus.op)
      OPW'(OP_ADD): begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OPW'(OP_ADDU): begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
      end
      OPW'(OP_SUB): begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = ~w_diff[WIDTH];
        w_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OPW'(OP_SUBU): begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = ~w_diff[WIDTH];
      end
      OPW'(OP_AND):  w_res = bus.a & bus.b;
      OPW'(OP_OR):   w_res = bus.a | bus.b;
      OPW'(OP_XOR):  w_res = bus.a ^ bus.b;
      OPW'(OP_SLT):  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OPW'(OP_SLTU): w_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OPW'(OP_LUI):  w_res = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default:       w_known = 1'b0;
    endcase
    // Undefined opcodes report every flag low, including zero.
    w_zero = w_known && (w_res == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_result    <= '0;
      r_result_hi <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_div_zero  <= 1'b0;
      r_b_zero    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (!w_accept) begin
            r_state <= ST_IDLE;
          end else if (w_is_mul) begin
            r_state <= ST_MUL;
          end else if (w_is_div) begin
            r_state  <= ST_DIV;
            r_b_zero <= (bus.b == '0);
          end else begin
            r_state     <= ST_DONE;
            r_result    <= w_res;
            r_result_hi <= '0;
            r_carry     <= w_carry;
            r_ovf       <= w_ovf;
            r_zero      <= w_zero;
            r_div_zero  <= 1'b0;
          end
        end
        ST_MUL, ST_DIV: begin
          if (w_md_done) begin
            r_state     <= ST_DONE;
            r_result    <= w_md_lo;
            r_result_hi <= w_md_hi;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= (w_md_lo == '0);
            r_div_zero  <= (r_state == ST_DIV) && r_b_zero;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.result    = r_result;
  assign bus.result_hi = r_result_hi;
  assign bus.carry_out = r_carry;
  assign bus.overflow  = r_ovf;
  assign bus.zero      = r_zero;
  assign bus.div_zero  = r_div_zero;

endmodule

// File: tb/tb_iter_alu.sv
// Directed self-checking bench for iter_alu at WIDTH = 32: arithmetic/logic flags,
// iterative latency, back-to-back issue, divide-by-zero and reset abort.
module tb_iter_alu;
  import iter_alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  logic ready_seen;
  logic valid_seen;

  always #5 clk = ~clk;

  iter_alu_if #(.WIDTH(32), .OPW(4)) bus ();

  iter_alu #(.WIDTH(32), .OPW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request in the current cycle, then move to the next cycle and scramble the inputs.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    chk("accept_ready", {63'd0, bus.in_ready}, 64'd1);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op       = OP_ADD;
    bus.a        = 32'hDEADBEEF;
    bus.b        = 32'h0BADF00D;
  endtask

  task automatic expect_res(input string tag, input int exp_lat,
                            input logic [31:0] r, input logic [31:0] hi,
                            input logic c, input logic o, input logic z, input logic dz);
    int lat;
    lat = 1;
    ready_seen = 1'b0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      if (bus.in_ready === 1'b1) ready_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    $display("txn %s: latency=%0d result=%h result_hi=%h c=%b o=%b z=%b dz=%b", tag, lat,
             bus.result, bus.result_hi, bus.carry_out, bus.overflow, bus.zero, bus.div_zero);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, {32'd0, bus.result}, {32'd0, r});
    chk({tag, "_hi"}, {32'd0, bus.result_hi}, {32'd0, hi});
    chk({tag, "_carry"}, {63'd0, bus.carry_out}, {63'd0, c});
    chk({tag, "_ovf"}, {63'd0, bus.overflow}, {63'd0, o});
    chk({tag, "_zero"}, {63'd0, bus.zero}, {63'd0, z});
    chk({tag, "_dz"}, {63'd0, bus.div_zero}, {63'd0, dz});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.op       = '0;
    bus.a        = '0;
    bus.b        = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_result", {32'd0, bus.result}, 64'd0);
    chk("rst_flags", {60'd0, bus.carry_out, bus.overflow, bus.zero, bus.div_zero}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", {63'd0, bus.in_ready}, 64'd1);

    issue(OP_ADD, 32'h7FFFFFFF, 32'h00000001);
    expect_res("add_ovf", 1, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("hold_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("hold_result", {32'd0, bus.result}, 64'h80000000);

    issue(OP_ADDU, 32'hFFFFFFFF, 32'h00000001);
    expect_res("addu_wrap", 1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(OP_SUB, 32'h80000000, 32'h00000001);
    expect_res("sub_ovf", 1, 32'h7FFFFFFF, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    issue(OP_SUBU, 32'h00000001, 32'h00000002);
    expect_res("subu_borrow", 1, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(OP_SLT, 32'h80000000, 32'h00000001);
    expect_res("slt_neg", 1, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(OP_SLTU, 32'h80000000, 32'h00000001);
    expect_res("sltu_big", 1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(OP_SLT, 32'h7FFFFFFF, 32'h80000000);
    expect_res("slt_edge", 1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(OP_SLTU, 32'h7FFFFFFF, 32'h80000000);
    expect_res("sltu_edge", 1, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(OP_AND, 32'hF0F01234, 32'h0FF0FF00);
    expect_res("and", 1, 32'h00F01200, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(OP_OR, 32'hF0F01234, 32'h0FF0FF00);
    expect_res("or", 1, 32'hFFF0FF34, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(OP_XOR, 32'hF0F01234, 32'h0FF0FF00);
    expect_res("xor", 1, 32'hFF00ED34, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(OP_LUI, 32'h12345678, 32'hFFFFABCD);
    expect_res("lui", 1, 32'hABCD0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'hF, 32'h00000005, 32'h00000007);
    expect_res("undef", 1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    issue(OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    expect_res("mulu_max", 33, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mulu_busy_ready", {63'd0, ready_seen}, 64'd0);
    // Issue ADDU in the DONE cycle of the multiply.
    issue(OP_ADDU, 32'h00000002, 32'h00000003);
    expect_res("b2b_addu", 1, 32'h00000005, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    issue(OP_MULU, 32'h00012345, 32'h00010000);
    expect_res("mulu_shift", 33, 32'h23450000, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(OP_DIVU, 32'h00000100, 32'h00000007);
    expect_res("divu", 33, 32'h00000024, 32'h00000004, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(OP_DIVU, 32'h00000055, 32'h00000000);
    expect_res("divu_zero", 33, 32'hFFFFFFFF, 32'h00000055, 1'b0, 1'b0, 1'b0, 1'b1);

    // Abort a divide with reset during cycle N+10.
    @(posedge clk); #1;
    issue(OP_DIVU, 32'h00001000, 32'h00000003);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_result", {bus.result_hi, bus.result}, 64'd0);
    chk("abort_flags", {60'd0, bus.carry_out, bus.overflow, bus.zero, bus.div_zero}, 64'd0);
    chk("abort_ready", {63'd0, bus.in_ready}, 64'd1);
    valid_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid === 1'b1) valid_seen = 1'b1;
      @(posedge clk); #1;
    end
    $display("txn abort_div: out_valid_seen=%b", valid_seen);
    chk("abort_no_valid", {63'd0, valid_seen}, 64'd0);

    issue(OP_SUBU, 32'h00000009, 32'h00000004);
    expect_res("post_rst", 1, 32'h00000005, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, operand/result width in bits (legal 8..64, even).
REQ-002 The module SHALL have parameter OPW, default 4, opcode width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  unit can accept a request this cycle.
REQ-007 op  input  OPW  operation code (encodings in shared package).
REQ-008 a, b  input  WIDTH each  operands (a = Rs, b = Rt/immediate, already extended by caller).
REQ-009 out_valid  output  1  one-cycle pulse: result fields valid.
REQ-010 result  output  WIDTH  low result / quotient.
REQ-011 result_hi  output  WIDTH  product high half / remainder; 0 for single-cycle ops.
REQ-012 carry_out, overflow, zero, div_zero  output  1 each  status flags.

Function
REQ-013 Ops: ADD, ADDU, SUB, SUBU, AND, OR, XOR, SLT, SLTU, LUI, MULU, DIVU.
REQ-014 ADD/ADDU: result = a+b mod 2^WIDTH; carry_out = bit WIDTH of sum; overflow only for ADD (a,b same sign, result sign differs).
REQ-015 SUB/SUBU: result = a-b; carry_out = no-borrow (a >= b unsigned); overflow only for SUB (a,b signs differ, result sign != a sign).
REQ-016 SLT = {0.., a<b signed}, SLTU = {0.., a<b unsigned}; comparisons SHALL be correct across sign boundaries, independent of subtraction overflow.
REQ-017 LUI: result = {b[WIDTH/2-1:0], WIDTH/2 zeros}.
REQ-018 carry_out and overflow SHALL be 0 for all ops not named in REQ-014/015; zero = (result == 0) for every op.
REQ-019 FSM states: IDLE, MUL, DIV, DONE; in_ready = 1 in IDLE and DONE, 0 in MUL/DIV.
REQ-020 Accept = in_valid & in_ready; operands and op SHALL be captured on accept; input changes afterwards have no effect.
REQ-021 Single-cycle op accepted in cycle N: out_valid = 1 in cycle N+1 (state DONE).
REQ-022 MULU: unsigned shift-add, one bit per cycle, WIDTH cycles in MUL; out_valid in cycle N+WIDTH+1; {result_hi,result} = full 2*WIDTH-bit product.
REQ-023 DIVU: restoring division, WIDTH cycles in DIV; result = quotient, result_hi = remainder; same latency as MULU.
REQ-024 DIVU with b = 0: SHALL still take full latency; result = all ones, result_hi = a, div_zero = 1; div_zero = 0 otherwise.
REQ-025 DONE lasts exactly one cycle; a request accepted in DONE starts immediately (back-to-back, no bubble); otherwise return to IDLE.
REQ-026 Output fields SHALL hold their last values until the next out_valid; out_valid never asserts without a prior accept.
REQ-027 Undefined op codes: result = 0, result_hi = 0, all flags 0, single-cycle latency.

Reset
REQ-028 Reset SHALL force state IDLE, out_valid 0, result/result_hi 0, all flags 0; in_ready = 1 in the first cycle after reset deasserts.
REQ-029 Reset asserted during MUL/DIV SHALL abort the operation with no out_valid for it.

Structure
REQ-030 A shared package iter_alu_pkg SHALL hold op encodings (OPW) and FSM state type.
REQ-031 The iterative engine SHALL be a sub-module iter_muldiv (start, op select, a, b -> busy, done, lo, hi).
REQ-032 Single-cycle datapath SHALL be combinational from captured operands into registered outputs.

Verification (WIDTH = 32)
REQ-033 ADD a=7FFFFFFF, b=1 -> result 80000000, overflow 1, carry 0, out_valid at N+1.
REQ-034 SLT a=80000000, b=1 -> result 1; SLTU same operands -> result 0.
REQ-035 MULU a=FFFFFFFF, b=FFFFFFFF -> result_hi FFFFFFFE, result 00000001, out_valid at N+33, in_ready 0 cycles N+1..N+32.
REQ-036 DIVU a=100, b=7 -> result 24, result_hi 4; DIVU b=0, a=55 -> result FFFFFFFF, result_hi 55, div_zero 1.
REQ-037 Back-to-back: ADDU issued in DONE cycle of MULU -> ADDU out_valid next cycle, MULU results unchanged until then.
REQ-038 Reset at cycle N+10 of DIVU -> no out_valid, all outputs 0, in_ready 1 after reset.
